// File: rtl/sfft_stream_decoder.sv
// Converts the stochastic FFT's per-lane unary bitstreams to binary counts over 2^BITWIDTH-sample windows.
// Define SFFT_DECODE_BIPOLAR_EN to emit signed bipolar results (2*count - 2^BITWIDTH) instead of raw counts.
//
//   state | meaning
//   EMPTY | result registers hold no unconsumed window (oValid=0)
//   FULL  | result registers hold an unconsumed window (oValid=1)
module sfft_stream_decoder #(
  parameter int NUMINPUTS = 2,
  parameter int BITWIDTH  = 8,
`ifdef SFFT_DECODE_BIPOLAR_EN
  localparam int OW = BITWIDTH + 2
`else
  localparam int OW = BITWIDTH + 1
`endif
) (
  input  logic                    iClk,
  input  logic                    iRstN,
  input  logic                    iEn,
  input  logic                    iClr,
  input  logic [NUMINPUTS-1:0]    iReal,
  input  logic [NUMINPUTS-1:0]    iImg,
  input  logic                    iReady,
  output logic [NUMINPUTS*OW-1:0] oReal,
  output logic [NUMINPUTS*OW-1:0] oImg,
  output logic                    oValid,
  output logic                    oOverrun
);

  localparam int CW = BITWIDTH + 1;

  typedef enum logic {EMPTY, FULL} state_e;

  state_e                         state_q, state_d;
  logic [BITWIDTH-1:0]            win_q, win_d;
  logic [NUMINPUTS-1:0][CW-1:0]   cnt_re_q, cnt_re_d, cnt_im_q, cnt_im_d;
  logic [NUMINPUTS-1:0][OW-1:0]   res_re_q, res_re_d, res_im_q, res_im_d;
  logic                           ovr_q, ovr_d;
  logic                           sample, win_end, xfer;

  // The final sample is folded in here so a full window of ones reaches 2^BITWIDTH.
  function automatic logic [OW-1:0] to_result(input logic [CW-1:0] cnt, input logic bit_in);
    logic [CW-1:0] sum;
    sum = cnt + CW'(bit_in);
`ifdef SFFT_DECODE_BIPOLAR_EN
    return {sum, 1'b0} - (OW'(1) << BITWIDTH);
`else
    return sum;
`endif
  endfunction

  always_comb begin
    sample   = iEn && !iClr;
    win_end  = sample && (win_q == '1);
    xfer     = (state_q == FULL) && iReady;
    win_d    = win_q;
    cnt_re_d = cnt_re_q;
    cnt_im_d = cnt_im_q;
    res_re_d = res_re_q;
    res_im_d = res_im_q;

    if (iClr) begin
      win_d    = '0;
      cnt_re_d = '0;
      cnt_im_d = '0;
    end else if (sample) begin
      win_d = win_q + BITWIDTH'(1);
      for (int k = 0; k < NUMINPUTS; k++) begin
        if (win_end) begin
          res_re_d[k] = to_result(cnt_re_q[k], iReal[k]);
          res_im_d[k] = to_result(cnt_im_q[k], iImg[k]);
          cnt_re_d[k] = '0;
          cnt_im_d[k] = '0;
        end else begin
          cnt_re_d[k] = cnt_re_q[k] + CW'(iReal[k]);
          cnt_im_d[k] = cnt_im_q[k] + CW'(iImg[k]);
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ovr_d   = ovr_q;
    if (iClr) begin
      state_d = EMPTY;
      ovr_d   = 1'b0;
    end else begin
      case (state_q)
        EMPTY: if (win_end) state_d = FULL;
        FULL: begin
          if (win_end) begin
            state_d = FULL;
            if (!xfer) ovr_d = 1'b1;
          end else if (xfer) begin
            state_d = EMPTY;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state_q  <= EMPTY;
      win_q    <= '0;
      cnt_re_q <= '0;
      cnt_im_q <= '0;
      res_re_q <= '0;
      res_im_q <= '0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      cnt_re_q <= cnt_re_d;
      cnt_im_q <= cnt_im_d;
      res_re_q <= res_re_d;
      res_im_q <= res_im_d;
      ovr_q    <= ovr_d;
    end
  end

  assign oReal    = res_re_q;
  assign oImg     = res_im_q;
  assign oValid   = (state_q == FULL);
  assign oOverrun = ovr_q;

endmodule

// File: tb/tb_sfft_stream_decoder.sv
// Scoreboard bench for sfft_stream_decoder (NUMINPUTS=4, BITWIDTH=4); follows SFFT_DECODE_BIPOLAR_EN if defined.
module tb_sfft_stream_decoder;
  localparam int N   = 4;
  localparam int B   = 4;
  localparam int WIN = 16;
`ifdef SFFT_DECODE_BIPOLAR_EN
  localparam int OW = B + 2;
`else
  localparam int OW = B + 1;
`endif
  localparam int PW = N * OW;

  logic          iClk = 1'b0, iRstN = 1'b0, iEn = 1'b0, iClr = 1'b0, iReady = 1'b0;
  logic [N-1:0]  iReal = '0, iImg = '0;
  logic [PW-1:0] oReal, oImg;
  logic          oValid, oOverrun;

  sfft_stream_decoder #(.NUMINPUTS(N), .BITWIDTH(B)) dut (
    .iClk(iClk), .iRstN(iRstN), .iEn(iEn), .iClr(iClr), .iReal(iReal), .iImg(iImg),
    .iReady(iReady), .oReal(oReal), .oImg(oImg), .oValid(oValid), .oOverrun(oOverrun)
  );

  always #5 iClk = ~iClk;

  int n_err = 0;
  int n_chk = 0;

  int mdl_win;
  int cr[N];
  int ci[N];
  bit mdl_valid, mdl_ovr;
  logic [2*PW-1:0] sb_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [OW-1:0] conv(input int c);
`ifdef SFFT_DECODE_BIPOLAR_EN
    return OW'(2 * c - WIN);
`else
    return OW'(c);
`endif
  endfunction

  function automatic logic [PW-1:0] pack4(input int a, input int b, input int c, input int d);
    return {conv(d), conv(c), conv(b), conv(a)};
  endfunction

  // mode 0: test-plan pattern, 1: all ones, 2: all zeros
  function automatic bit lane_bit(input int mode, input int lane, input int s);
    if (mode == 1) return 1'b1;
    if (mode == 2) return 1'b0;
    case (lane)
      0: return 1'b1;
      1: return 1'b0;
      2: return (s % 2) == 0;
      default: return s < 5;
    endcase
  endfunction

  task automatic mdl_reset();
    mdl_win   = 0;
    mdl_valid = 1'b0;
    mdl_ovr   = 1'b0;
    for (int k = 0; k < N; k++) begin
      cr[k] = 0;
      ci[k] = 0;
    end
    sb_q.delete();
  endtask

  task automatic cyc(input bit en, input bit clr, input bit rdy, input int mode);
    bit xf, we;
    logic [2*PW-1:0] e;
    iEn = en;
    iClr = clr;
    iReady = rdy;
    for (int k = 0; k < N; k++) begin
      iReal[k] = lane_bit(mode, k, mdl_win);
      iImg[k]  = !lane_bit(mode, k, mdl_win);
    end
    chk("valid", oValid, mdl_valid);
    chk("overrun", oOverrun, mdl_ovr);
    xf = mdl_valid && rdy;
    if (xf) begin
      if (sb_q.size() == 0) chk("sb_empty", 1, 0);
      else begin
        e = sb_q.pop_front();
        chk("real", oReal, e[2*PW-1:PW]);
        chk("img", oImg, e[PW-1:0]);
      end
    end
    we = en && !clr && (mdl_win == WIN - 1);
    if (clr) begin
      mdl_reset();
    end else begin
      if (xf) mdl_valid = 1'b0;
      if (en) begin
        for (int k = 0; k < N; k++) begin
          cr[k] += int'(iReal[k]);
          ci[k] += int'(iImg[k]);
        end
        if (we) begin
          if (mdl_valid) begin
            void'(sb_q.pop_back());
            mdl_ovr = 1'b1;
          end
          sb_q.push_back({pack4(cr[0], cr[1], cr[2], cr[3]), pack4(ci[0], ci[1], ci[2], ci[3])});
          for (int k = 0; k < N; k++) begin
            cr[k] = 0;
            ci[k] = 0;
          end
          mdl_valid = 1'b1;
          mdl_win = 0;
        end else begin
          mdl_win++;
        end
      end
    end
    @(posedge iClk);
    #1;
  endtask

  initial begin
    mdl_reset();
    #12;
    chk("rst_valid", oValid, 0);
    chk("rst_ovr", oOverrun, 0);
    chk("rst_real", oReal, 0);
    chk("rst_img", oImg, 0);
    iRstN = 1'b1;

    // one window, consumer always ready
    repeat (WIN) cyc(1, 0, 1, 0);
    chk("t1_valid", oValid, 1);
    chk("t1_real", oReal, pack4(16, 0, 8, 5));
    chk("t1_img", oImg, pack4(0, 16, 8, 11));
    repeat (2) cyc(1, 0, 1, 0);
    chk("t1_valid_drop", oValid, 0);
    cyc(0, 1, 1, 0);

    // enable every other cycle
    for (int i = 0; i < 2 * WIN; i++) cyc(i % 2 == 1, 0, 1, 0);
    chk("t2_valid", oValid, 1);
    chk("t2_real", oReal, pack4(16, 0, 8, 5));
    cyc(0, 0, 1, 0);
    cyc(0, 1, 1, 0);

    // overrun: two windows without a consumer
    repeat (WIN) cyc(1, 0, 0, 1);
    repeat (WIN) cyc(1, 0, 0, 2);
    chk("t3_valid", oValid, 1);
    chk("t3_ovr", oOverrun, 1);
    chk("t3_real", oReal, pack4(0, 0, 0, 0));
    chk("t3_img", oImg, pack4(16, 16, 16, 16));
    repeat (2) cyc(0, 0, 1, 0);
    chk("t3_valid_drop", oValid, 0);
    chk("t3_ovr_sticky", oOverrun, 1);
    cyc(0, 1, 0, 0);
    chk("t3_ovr_clr", oOverrun, 0);

    // window end coinciding with a transfer
    repeat (WIN) cyc(1, 0, 0, 0);
    repeat (WIN - 1) cyc(1, 0, 0, 1);
    cyc(1, 0, 1, 1);
    chk("t4_valid", oValid, 1);
    chk("t4_ovr", oOverrun, 0);
    chk("t4_real", oReal, pack4(16, 16, 16, 16));
    cyc(0, 0, 1, 0);
    cyc(0, 1, 0, 0);

    // asynchronous reset mid-window
    repeat (7) cyc(1, 0, 1, 0);
    iRstN = 1'b0;
    mdl_reset();
    #2;
    chk("t5_rst_real", oReal, 0);
    chk("t5_rst_img", oImg, 0);
    chk("t5_rst_valid", oValid, 0);
    iRstN = 1'b1;
    repeat (WIN - 1) cyc(1, 0, 1, 0);
    chk("t5_no_early", oValid, 0);
    cyc(1, 0, 1, 0);
    chk("t5_valid", oValid, 1);
    chk("t5_real", oReal, pack4(16, 0, 8, 5));
    repeat (2) cyc(0, 0, 1, 0);
    chk("sb_drain", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
